// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: two-entry skid-buffered stage between fetch and
// decode. The head (main) register drives decode; the skid register catches
// the one extra instruction fetch may push while decode stalls. This lets
// in_ready come straight from a flop instead of depending on out_ready.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready
// are both high on that side. A producer holds valid and its data steady
// until the transfer completes. A consumer may change ready at any time.
// ready never depends combinationally on valid.
module if_id_pipe_reg #(
  parameter int PC_WIDTH    = 64,
  parameter int INSTR_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = INSTR_WIDTH'(32'h00000013)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_WIDTH-1:0]    in_pc,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [1:0]             occupancy
);

  // State value equals the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic                   in_ready_q;
  logic                   main_valid;
  logic                   skid_valid;
  logic [PC_WIDTH-1:0]    main_pc;
  logic [INSTR_WIDTH-1:0] main_instr;
  logic [PC_WIDTH-1:0]    skid_pc;
  logic [INSTR_WIDTH-1:0] skid_instr;

  logic accept;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid_in;

  assign accept     = in_valid & in_ready_q;
  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == TWO);

  // Next-state and register-load selection; flush overrides everything.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (out_ready) begin
          if (accept) begin
            load_main_in = 1'b1;
          end else begin
            state_d = EMPTY;
          end
        end else if (accept) begin
          state_d      = TWO;
          load_skid_in = 1'b1;
        end
      end
      TWO: begin
        if (out_ready) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (flush) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
    end
  end

  // State register and registered in_ready (low only when both slots fill).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  // Data registers; only valid bits change on dequeue, fields stay put.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_pc    <= '0;
      main_instr <= NOP_INSTR;
      skid_pc    <= '0;
      skid_instr <= NOP_INSTR;
    end else begin
      if (load_main_in) begin
        main_pc    <= in_pc;
        main_instr <= in_instr;
      end else if (load_main_skid) begin
        main_pc    <= skid_pc;
        main_instr <= skid_instr;
      end
      if (load_skid_in) begin
        skid_pc    <= in_pc;
        skid_instr <= in_instr;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_pc    = main_pc;
  assign out_instr = main_valid ? main_instr : NOP_INSTR;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
Parametrised IF/ID pipeline register for the RISC-V core. It replaces the fixed 64/32-bit latch with a 2-entry skid-buffered valid/ready stage between fetch and decode. The stage supports back-pressure from decode without a combinational ready path, and a synchronous flush that squashes held instructions into NOP bubbles for branch/jump redirects.

Parameters:
PC_WIDTH, 64, width of program-counter field
INSTR_WIDTH, 32, width of instruction field
NOP_INSTR, 32'h00000013, instruction presented when stage holds no valid entry (addi x0,x0,0)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  fetch presents a PC/instruction pair
in_ready  output  1  stage can accept; transfer when in_valid & in_ready at clk edge
in_pc  input  PC_WIDTH  fetched PC
in_instr  input  INSTR_WIDTH  fetched instruction
flush  input  1  synchronous squash of all held entries (branch redirect)
out_valid  output  1  decode-side entry valid
out_ready  input  1  decode consumes; transfer when out_valid & out_ready at clk edge
out_pc  output  PC_WIDTH  PC of head entry
out_instr  output  INSTR_WIDTH  instruction of head entry, NOP_INSTR when !out_valid
occupancy  output  2  number of held entries, 0..2

Behaviour:
- Storage: main register (head, drives outputs) and skid register, each with a valid bit. State is encoded as EMPTY (0), ONE (main valid), TWO (main + skid valid).
- in_ready = !skid_valid, driven directly from a flop with no combinational path from out_ready. It is 1 in EMPTY/ONE and 0 in TWO.
- out_valid = main_valid. out_pc = main_pc. out_instr = main_valid ? main_instr : NOP_INSTR. occupancy = main_valid + skid_valid.
- Latency: accepted input appears on outputs the cycle after acceptance. Throughput is 1 per cycle while out_ready = 1.
- Transitions (flush = 0):
  - EMPTY: in_valid -> ONE, main <= in; else stay.
  - ONE, out_ready & in_valid -> ONE, main <= in.
  - ONE, out_ready & !in_valid -> EMPTY.
  - ONE, !out_ready & in_valid -> TWO, skid <= in, main unchanged.
  - ONE, !out_ready & !in_valid -> stay.
  - TWO: input ignored (in_ready = 0). out_ready -> ONE, main <= skid. Else stay.
- Ordering: entries leave in acceptance order. An entry is never duplicated or dropped except by flush.
- Stability: while out_valid & !out_ready, out_pc/out_instr must not change.
- Flush:
  - Next state is EMPTY, both valid bits clear, regardless of in_valid/out_ready.
  - An input handshaking in the same cycle is discarded; fetch treats it as consumed.
  - out_instr shows NOP_INSTR from the following cycle.
  - Flush has priority over every other event.
- Reset (asserted at any time, including mid-transfer or in TWO): immediately, without waiting for a clock edge:
  - main_valid = skid_valid = 0, so out_valid = 0.
  - main_pc = skid_pc = 0, so out_pc = 0.
  - main_instr = skid_instr = NOP_INSTR.
  - in_ready = 1, occupancy = 0.
  - No handshakes occur while reset is high. Normal operation resumes at the first clk edge after deassertion.
- Data fields are not cleared on dequeue; only valid bits change. out_pc with !out_valid is don't-care except after reset (0).

Test Plan:
- Reset mid-stream: fill to TWO with PCs 0x100/0x104, assert reset between edges -> out_valid = 0, out_pc = 0, out_instr = 0x00000013, in_ready = 1, occupancy = 0 immediately, before any clk edge.
- Streaming: out_ready = 1, push PC 0x0,0x4,0x8 with instr 0x00500093,0x00100113,0x002081B3 back-to-back -> same triples on outputs one cycle later, in order, out_valid held 1 for 3 cycles, occupancy ≤ 1.
- Back-pressure: out_ready = 0, push 0x200 then 0x204 -> occupancy 2, in_ready = 0, 0x208 held by fetch not accepted. Raise out_ready -> 0x200, 0x204, 0x208 emerge in order with no loss.
- Flush with simultaneous accept: in TWO, assert flush with in_valid = 1 (PC 0x300) -> next cycle out_valid = 0, out_instr = 0x00000013, occupancy = 0, 0x300 never appears.
- Output stability: hold out_ready = 0 for 5 cycles with head PC 0x400 -> out_pc/out_instr constant all 5 cycles while input toggles.
- Parameter sweep: PC_WIDTH = 32, INSTR_WIDTH = 16, NOP_INSTR = 16'h0001 -> empty stage shows 0x0001. Streaming scenario passes with 32-bit PCs.
